// File: rtl/i3c_pad_ctrl.sv
// Pad-side glue for NumLanes independent I3C buses: input sync + spike filter,
// START/STOP and bus-free detection, registered open-drain/push-pull pad drive.
module i3c_pad_ctrl #(
  parameter int NumLanes   = 1,
  parameter int SyncStages = 2,
  parameter int FiltW      = 4,
  parameter int IdleCntW   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [FiltW-1:0]    filt_len_i,
  input  logic [IdleCntW-1:0] bus_free_thld_i,
  input  logic [NumLanes-1:0] scl_pad_i,
  input  logic [NumLanes-1:0] sda_pad_i,
  input  logic [NumLanes-1:0] scl_ctrl_i,
  input  logic [NumLanes-1:0] sda_ctrl_i,
  input  logic [NumLanes-1:0] sel_od_pp_i,
  input  logic [NumLanes-1:0] scl_drive_en_i,
  output logic [NumLanes-1:0] scl_o,
  output logic [NumLanes-1:0] sda_o,
  output logic [NumLanes-1:0] scl_pad_o,
  output logic [NumLanes-1:0] sda_pad_o,
  output logic [NumLanes-1:0] scl_pad_oe,
  output logic [NumLanes-1:0] sda_pad_oe,
  output logic [NumLanes-1:0] start_det_o,
  output logic [NumLanes-1:0] stop_det_o,
  output logic [NumLanes-1:0] bus_free_o
);

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    logic [1:0]          raw;   // bit 0 = SCL, bit 1 = SDA
    logic [1:0]          filt;
    logic [1:0]          filt_prev_q;
    logic                scl_f;
    logic                sda_f;
    logic                scl_q;
    logic                sda_q;
    logic                pp_q;
    logic                drv_en_q;
    logic                scl_hold_q;
    logic                sda_hold_q;
    logic                start_q;
    logic                stop_q;
    logic                bus_free_q;
    logic [IdleCntW-1:0] idle_cnt_q;

    assign raw   = {sda_pad_i[l], scl_pad_i[l]};
    assign scl_f = filt[0];
    assign sda_f = filt[1];

    for (genvar s = 0; s < 2; s++) begin : g_sig
      logic [SyncStages-1:0] sync_q;
      logic [FiltW-1:0]      cnt_q;
      logic                  filt_bit_q;
      logic                  synced;

      assign synced  = sync_q[SyncStages-1];
      assign filt[s] = filt_bit_q;

      // Compare against the live length so a shortened filter releases at once.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          sync_q     <= '1;
          cnt_q      <= '0;
          filt_bit_q <= 1'b1;
        end else begin
          sync_q <= {sync_q[SyncStages-2:0], raw[s]};
          if (synced == filt_bit_q) begin
            cnt_q <= '0;
          end else if (cnt_q >= filt_len_i) begin
            filt_bit_q <= synced;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        filt_prev_q <= 2'b11;
        start_q     <= 1'b0;
        stop_q      <= 1'b0;
        idle_cnt_q  <= '0;
        bus_free_q  <= 1'b0;
      end else begin
        filt_prev_q <= filt;
        start_q     <= filt_prev_q[0] & scl_f & filt_prev_q[1] & ~sda_f;
        stop_q      <= filt_prev_q[0] & scl_f & ~filt_prev_q[1] & sda_f;
        if (!(scl_f && sda_f) || start_q) begin
          idle_cnt_q <= '0;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
        bus_free_q <= (idle_cnt_q >= bus_free_thld_i) & scl_f & sda_f;
      end
    end

    // Hold flops keep a high level actively driven for one cycle when leaving push-pull.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        scl_q      <= 1'b1;
        sda_q      <= 1'b1;
        pp_q       <= 1'b0;
        drv_en_q   <= 1'b0;
        scl_hold_q <= 1'b0;
        sda_hold_q <= 1'b0;
      end else begin
        scl_q      <= scl_ctrl_i[l];
        sda_q      <= sda_ctrl_i[l];
        pp_q       <= sel_od_pp_i[l];
        drv_en_q   <= scl_drive_en_i[l];
        scl_hold_q <= pp_q & ~sel_od_pp_i[l] & scl_ctrl_i[l];
        sda_hold_q <= pp_q & ~sel_od_pp_i[l] & sda_ctrl_i[l];
      end
    end

    assign scl_o[l]       = scl_f;
    assign sda_o[l]       = sda_f;
    assign scl_pad_o[l]   = scl_q;
    assign sda_pad_o[l]   = sda_q;
    assign sda_pad_oe[l]  = pp_q | ~sda_q | sda_hold_q;
    assign scl_pad_oe[l]  = drv_en_q & (pp_q | ~scl_q | scl_hold_q);
    assign start_det_o[l] = start_q;
    assign stop_det_o[l]  = stop_q;
    assign bus_free_o[l]  = bus_free_q;
  end

endmodule

// File: doc/i3c_pad_ctrl.md
Name: i3c_pad_ctrl

Overview:
- Parametrised successor to the single-lane pad glue used at the I3C wrapper boundary.
- Handles NumLanes independent I3C buses. Per lane it provides:
  - input synchronisation and a programmable spike filter on SCL/SDA;
  - START/STOP detection and a bus-free timer;
  - registered open-drain/push-pull pad drive for both SDA and SCL, with SCL drive supporting controller mode.
- Sits between the I3C core (or cores) and the pad ring.

Parameters:
- NumLanes, 1, number of independent SCL/SDA pairs.
- SyncStages, 2, synchroniser depth (≥2).
- FiltW, 4, width of spike-filter length and counter.
- IdleCntW, 16, width of bus-free counter and threshold.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  synchronous, active-high reset.
- filt_len_i  in  FiltW  spike-filter length in cycles, shared by all lanes.
- bus_free_thld_i  in  IdleCntW  cycles both lines must be high before bus_free_o asserts.
- scl_pad_i, sda_pad_i  in  NumLanes  raw pad inputs.
- scl_ctrl_i, sda_ctrl_i  in  NumLanes  line level requested by core (0 = pull low).
- sel_od_pp_i  in  NumLanes  1 = push-pull, 0 = open-drain.
- scl_drive_en_i  in  NumLanes  1 = lane may drive SCL (controller role).
- scl_o, sda_o  out  NumLanes  filtered line levels to core.
- scl_pad_o, sda_pad_o  out  NumLanes  pad output value.
- scl_pad_oe, sda_pad_oe  out  NumLanes  pad output enables.
- start_det_o, stop_det_o  out  NumLanes  one-cycle condition pulses.
- bus_free_o  out  NumLanes  bus idle/free indication.

Behaviour:
- Reset values (rst_i sampled high, synchronous):
  - synchroniser flops, filtered scl_o/sda_o, and pad_o registers = 1;
  - pad_oe registers = 0;
  - start_det_o/stop_det_o/bus_free_o = 0; all counters = 0.
- Assertion mid-transfer: the next edge forces the reset values; pulses in flight are dropped.
- Synchroniser: SyncStages flops per input.
- Spike filter (per signal):
  - If synced ≠ filtered: cnt++.
  - When cnt ≥ filt_len_i: filtered ← synced and cnt ← 0.
  - If synced == filtered: cnt ← 0.
  - filt_len_i = 0: filtered follows synced one cycle later.
  - Input-to-scl_o/sda_o latency = SyncStages + filt_len_i + 1 cycles.
  - Pulses shorter than filt_len_i + 1 cycles are suppressed.
  - filt_len_i may change at any time; the ≥ compare applies immediately.
- Output drive:
  - scl_ctrl_i, sda_ctrl_i, sel_od_pp_i and scl_drive_en_i are registered (1-cycle latency); pad_o = registered ctrl.
  - sda_pad_oe = pp_q | ~sda_q.
  - scl_pad_oe = drv_en_q & (pp_q | ~scl_q).
  - scl_drive_en_i = 0 forces scl_pad_oe = 0 regardless of mode.
- PP-to-OD handoff: when sel_od_pp_q falls while the registered level is 1, pad_oe stays 1 (actively driving high) for exactly one extra cycle, then releases. This applies to SDA, and to SCL when drive-enabled. OD-to-PP takes effect immediately.
- START: filtered sda 1→0 while filtered scl is 1 in both the previous and current cycle. STOP: filtered sda 0→1 under the same SCL condition. Each is a single-cycle pulse, registered one cycle after the filtered edge.
- Bus-free counter:
  - increments while filtered scl & sda are both 1; saturates at all-ones;
  - clears to 0 when either line is 0, or on start_det;
  - bus_free_o = (cnt ≥ bus_free_thld_i) & scl & sda, registered.
  - Threshold 0 asserts one cycle after both lines are seen high.
- Simultaneous SCL and SDA edges with no held-high SCL do not count as START/STOP.
- Lanes are fully independent; shared inputs (filt_len_i, bus_free_thld_i) are broadcast to all lanes.

Test Plan:
- Reset and filter latency:
  - Stimulus: rst_i high 3 cycles → check all reset values; then filt_len_i = 3, SyncStages = 2, drop sda_pad_i for 10 cycles.
  - Response: sda_o falls exactly 6 cycles after the input edge, no earlier.
- Glitch rejection:
  - Stimulus: filt_len_i = 3; 3-cycle low glitch on scl_pad_i.
  - Response: scl_o stays 1. A 4-cycle glitch propagates.
- START/STOP and bus free:
  - Stimulus: filt_len_i = 0, bus_free_thld_i = 5; scl high, sda 1→0, later 0→1.
  - Response: one start_det_o pulse, one stop_det_o pulse; bus_free_o rises 6 cycles after the filtered sda rise.
  - Follow-up: pulling scl low clears bus_free_o next cycle.
- OD/PP drive:
  - Stimulus: PP with sda_ctrl = 1, then switch to OD.
  - Response: sda_pad_oe = 1 for the handoff cycle, then 0. In OD, sda_ctrl = 0 gives oe = 1, pad_o = 0.
- SCL drive gating:
  - Stimulus: scl_drive_en_i = 0, PP, scl_ctrl = 0.
  - Response: scl_pad_oe = 0. Setting enable = 1 gives oe = 1 after one cycle.
- Multi-lane independence and reset mid-transfer:
  - Stimulus: NumLanes = 4, START on lane 2 only.
  - Response: start_det_o = 4'b0100.
  - Follow-up: asserting rst_i mid-START clears counters and pulses on the next edge.
